pwm_capture: RTL

- Input-capture receiver for PWM waveforms, such as those produced by the team's pwm generator or by external sources on a pad_gpio pin.
- Measures high time and period of the selected GPIO in prescaled mclk ticks and posts results with a valid pulse.
- Supports continuous and one-shot capture, input inversion and overflow detection.
- Sits beside the pwm block in the peripheral subsystem; configuration comes from the same register block.

---
 rtl/pwm_capture.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// PWM input-capture receiver: measures high time and period of a selected GPIO in prescaled mclk ticks.
// Optional glitch filter on the synchronized input is enabled by defining PWM_CAP_FILT_EN.
module pwm_capture #(
   parameter int FILT_DEPTH = 3
) (
   input  logic        mclk,
   input  logic        h_reset_n,
   input  logic [7:0]  pad_gpio,
   input  logic        cfg_cap_enb,
   input  logic [2:0]  cfg_cap_gpio_sel,
   input  logic        cfg_cap_inv,
   input  logic [3:0]  cfg_cap_scale,
   input  logic        cfg_cap_oneshot,
   output logic [15:0] cap_high,
   output logic [15:0] cap_period,
   output logic        cap_valid,
   output logic        cap_ovflow_pe,
   output logic        cap_os_done,
   output logic        cap_busy
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_RISE = 3'd1,
      ST_MEAS_HIGH = 3'd2,
      ST_MEAS_LOW  = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   state_t      state_r;
   logic        raw_s;
   logic        sync1_r;
   logic        sync2_r;
   logic        lvl_s;
   logic        lvl_l_r;
   logic        rise_s;
   logic        fall_s;
   logic [14:0] scnt_r;
   logic [14:0] mask_s;
   logic        tick_s;
   logic        meas_s;
   logic        ovf_s;
   logic [15:0] pcnt_r;
   logic [15:0] hcnt_r;
   logic [15:0] hsnap_r;
   logic [15:0] pcnt_inc_s;
   logic [15:0] hcnt_inc_s;

   assign raw_s = pad_gpio[cfg_cap_gpio_sel] ^ cfg_cap_inv;

   // two-flop synchronizer plus delayed level for edge detection
   always_ff @(posedge mclk or negedge h_reset_n) begin
      if (!h_reset_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         lvl_l_r <= 1'b0;
      end else begin
         sync1_r <= raw_s;
         sync2_r <= sync1_r;
         lvl_l_r <= lvl_s;
      end
   end

`ifdef PWM_CAP_FILT_EN
   logic [FILT_DEPTH-2:0] filt_sh_r;
   logic [FILT_DEPTH-1:0] win_s;
   logic                  filt_lvl_r;

   // the window includes the current sample so the filter adds exactly FILT_DEPTH cycles
   assign win_s = {filt_sh_r, sync2_r};
   assign lvl_s = filt_lvl_r;

   // level follows the input only once the whole window agrees on the new value
   always_ff @(posedge mclk or negedge h_reset_n) begin
      if (!h_reset_n) begin
         filt_sh_r  <= '0;
         filt_lvl_r <= 1'b0;
      end else begin
         filt_sh_r <= win_s[FILT_DEPTH-2:0];
         if ((&win_s) && !filt_lvl_r) begin
            filt_lvl_r <= 1'b1;
         end else if (!(|win_s) && filt_lvl_r) begin
            filt_lvl_r <= 1'b0;
         end else begin
            filt_lvl_r <= filt_lvl_r;
         end
      end
   end
`else
   logic unused_filt_s;

   assign lvl_s         = sync2_r;
   assign unused_filt_s = (FILT_DEPTH > 0);
`endif

   assign rise_s = lvl_s & ~lvl_l_r;
   assign fall_s = ~lvl_s & lvl_l_r;

   // at scale 15 the shift wraps to zero and the subtraction yields all ones
   assign mask_s     = (15'd1 << cfg_cap_scale) - 15'd1;
   assign tick_s     = ((scnt_r & mask_s) == mask_s);
   assign meas_s     = (state_r == ST_MEAS_HIGH) || (state_r == ST_MEAS_LOW);
   assign ovf_s      = meas_s && (pcnt_r == 16'hFFFF) && tick_s;
   assign pcnt_inc_s = pcnt_r + {15'd0, tick_s};
   assign hcnt_inc_s = hcnt_r + {15'd0, tick_s};

   // capture state machine with counters and registered status outputs
   always_ff @(posedge mclk or negedge h_reset_n) begin
      if (!h_reset_n) begin
         state_r       <= ST_IDLE;
         scnt_r        <= 15'd0;
         pcnt_r        <= 16'd0;
         hcnt_r        <= 16'd0;
         hsnap_r       <= 16'd0;
         cap_high      <= 16'd0;
         cap_period    <= 16'd0;
         cap_valid     <= 1'b0;
         cap_ovflow_pe <= 1'b0;
         cap_os_done   <= 1'b0;
         cap_busy      <= 1'b0;
      end else begin
         cap_valid     <= 1'b0;
         cap_ovflow_pe <= 1'b0;
         cap_os_done   <= 1'b0;
         if (!cfg_cap_enb) begin
            state_r  <= ST_IDLE;
            scnt_r   <= 15'd0;
            pcnt_r   <= 16'd0;
            hcnt_r   <= 16'd0;
            cap_busy <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  state_r  <= ST_WAIT_RISE;
                  cap_busy <= 1'b1;
               end
               ST_WAIT_RISE: begin
                  cap_busy <= 1'b1;
                  if (rise_s) begin
                     state_r <= ST_MEAS_HIGH;
                     scnt_r  <= 15'd0;
                     pcnt_r  <= 16'd0;
                     hcnt_r  <= 16'd0;
                  end else begin
                     state_r <= ST_WAIT_RISE;
                  end
               end
               ST_MEAS_HIGH, ST_MEAS_LOW: begin
                  // overflow outranks both edges; a coincident rise still opens a new measurement
                  if (ovf_s) begin
                     cap_ovflow_pe <= 1'b1;
                     cap_busy      <= 1'b1;
                     scnt_r        <= 15'd0;
                     pcnt_r        <= 16'd0;
                     hcnt_r        <= 16'd0;
                     state_r       <= rise_s ? ST_MEAS_HIGH : ST_WAIT_RISE;
                  end else if ((state_r == ST_MEAS_HIGH) && fall_s) begin
                     hsnap_r  <= hcnt_inc_s;
                     pcnt_r   <= pcnt_inc_s;
                     scnt_r   <= scnt_r + 15'd1;
                     cap_busy <= 1'b1;
                     state_r  <= ST_MEAS_LOW;
                  end else if ((state_r == ST_MEAS_LOW) && rise_s) begin
                     cap_high   <= hsnap_r;
                     cap_period <= pcnt_inc_s;
                     cap_valid  <= 1'b1;
                     scnt_r     <= 15'd0;
                     pcnt_r     <= 16'd0;
                     hcnt_r     <= 16'd0;
                     if (cfg_cap_oneshot) begin
                        cap_os_done <= 1'b1;
                        cap_busy    <= 1'b0;
                        state_r     <= ST_DONE;
                     end else begin
                        cap_busy <= 1'b1;
                        state_r  <= ST_MEAS_HIGH;
                     end
                  end else begin
                     pcnt_r   <= pcnt_inc_s;
                     hcnt_r   <= (state_r == ST_MEAS_HIGH) ? hcnt_inc_s : hcnt_r;
                     scnt_r   <= scnt_r + 15'd1;
                     cap_busy <= 1'b1;
                     state_r  <= state_r;
                  end
               end
               ST_DONE: begin
                  cap_busy <= 1'b0;
                  state_r  <= ST_DONE;
               end
               default: begin
                  cap_busy <= 1'b0;
                  state_r  <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule
